// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: framebuffer geometry, colour/address types and clear FSM states
// shared by the VGA framebuffer arbiter and its address helper.
package vga_fb_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int FB_AW    = 15;

    typedef logic [7:0]       fb_color_t;
    typedef logic [FB_AW-1:0] fb_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// fb_addr_calc: linear framebuffer address row*160 + col built from
// two shifts and an add, so no multiplier is needed.
module fb_addr_calc
    import vga_fb_pkg::*;
(
    input  logic [6:0] row_i,
    input  logic [7:0] col_i,
    output fb_addr_t   addr_o
);

    assign addr_o = {1'b0, row_i, 7'b0}
                  + {3'b0, row_i, 5'b0}
                  + {7'b0, col_i};

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: fixed-priority RAM scheduler (scan-out > clear > writer)
// with 2-cycle pixel output. Clear engine is built only with FB_CLEAR_EN.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter logic [9:0]  HACTIVE = 10'd640,
    parameter logic [9:0]  VACTIVE = 10'd480,
    parameter int unsigned FB_W    = 160,
    parameter int unsigned FB_H    = 120
) (
    input  logic       vgaclk,
    input  logic       reset,
    input  logic [9:0] counter_H,
    input  logic [9:0] counter_V,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_x,
    input  logic [6:0] wr_y,
    input  fb_color_t  wr_color,
    input  logic       clr_req,
    input  fb_color_t  clr_color,
    output logic       clr_busy,
    output fb_addr_t   ram_addr,
    output logic       ram_we,
    output fb_color_t  ram_wdata,
    input  fb_color_t  ram_rdata,
    output fb_color_t  pixel_color
);

    logic      active, disp_slot, free_slot, wr_in_range;
    fb_addr_t  disp_addr, wr_addr, last_disp_q;
    logic      disp_d1_q, act_d1_q;
    fb_color_t pixel_q, pixel_d;
    logic      clr_run;
    fb_addr_t  clr_addr;
    fb_color_t clr_data;

    assign active    = (counter_H < HACTIVE) && (counter_V < VACTIVE);
    assign disp_slot = active && (counter_H[1:0] == 2'b00);
    assign free_slot = !disp_slot;

    fb_addr_calc u_disp_addr (
        .row_i  (counter_V[8:2]),
        .col_i  (counter_H[9:2]),
        .addr_o (disp_addr)
    );

    fb_addr_calc u_wr_addr (
        .row_i  (wr_y),
        .col_i  (wr_x),
        .addr_o (wr_addr)
    );

    assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
    assign wr_ready    = free_slot && !clr_run;

`ifdef FB_CLEAR_EN
    localparam fb_addr_t CLR_LAST = fb_addr_t'(FB_DEPTH - 1);

    clr_state_t state_q, state_d;
    fb_addr_t   clr_addr_q, clr_addr_d;
    fb_color_t  clr_color_q, clr_color_d;

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d     = CLEAR;
                    clr_addr_d  = '0;
                    clr_color_d = clr_color;
                end
            end
            CLEAR: begin
                if (free_slot) begin
                    clr_addr_d = clr_addr_q + 1'b1;
                    if (clr_addr_q == CLR_LAST) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            state_q     <= IDLE;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
        end
    end

    assign clr_run  = (state_q == CLEAR);
    assign clr_addr = clr_addr_q;
    assign clr_data = clr_color_q;
    assign clr_busy = clr_run;
`else
    logic unused_clr;

    assign unused_clr = clr_req ^ (^clr_color);
    assign clr_run    = 1'b0;
    assign clr_addr   = '0;
    assign clr_data   = '0;
    assign clr_busy   = 1'b0;
`endif

    // Writes are suppressed while reset is held so a reset mid-clear stops at once.
    always_comb begin
        ram_addr  = last_disp_q;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (disp_slot) begin
            ram_addr = disp_addr;
        end else if (clr_run) begin
            ram_addr  = clr_addr;
            ram_we    = !reset;
            ram_wdata = clr_data;
        end else if (wr_valid) begin
            ram_addr  = wr_addr;
            ram_we    = wr_in_range && !reset;
            ram_wdata = wr_color;
        end
    end

    always_comb begin
        pixel_d = pixel_q;
        if (!act_d1_q) pixel_d = '0;
        else if (disp_d1_q) pixel_d = ram_rdata;
    end

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            last_disp_q <= '0;
            disp_d1_q   <= 1'b0;
            act_d1_q    <= 1'b0;
            pixel_q     <= '0;
        end else begin
            if (disp_slot) last_disp_q <= disp_addr;
            disp_d1_q <= disp_slot;
            act_d1_q  <= active;
            pixel_q   <= pixel_d;
        end
    end

    assign pixel_color = pixel_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: vector table, directed sequences and a randomized run
// against a spec-level model of the framebuffer arbiter.
module tb_vga_fb_arbiter;

    logic vgaclk = 1'b0;
    always #5 vgaclk = ~vgaclk;

    logic        reset;
    logic [9:0]  counter_H, counter_V;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [7:0]  wr_color;
    logic        clr_req;
    logic [7:0]  clr_color;
    logic        clr_busy;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata, pixel_color;

    logic        bd_we;
    logic [14:0] bd_addr;
    logic [7:0]  bd_data;

    logic [7:0] ram [0:19199];
    logic [7:0] mdl [0:19199];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    vga_fb_arbiter dut (
        .vgaclk      (vgaclk),
        .reset       (reset),
        .counter_H   (counter_H),
        .counter_V   (counter_V),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color),
        .clr_req     (clr_req),
        .clr_color   (clr_color),
        .clr_busy    (clr_busy),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .pixel_color (pixel_color)
    );

    // synchronous single-port RAM, 1-cycle read latency, plus a backdoor fill port
    always @(posedge vgaclk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (ram_we && ram_addr < 15'd19200) ram[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_addr < 15'd19200) ? ram[ram_addr] : 8'h00;
    end

    typedef struct packed {
        logic       rst;
        logic [9:0] h;
        logic [9:0] v;
        logic       wv;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] c;
        logic       cr;
        logic [7:0] cc;
    } in_t;

    in_t nx;

    typedef struct {
        int h, v;
        bit wv;
        int x, y, c;
        bit e_rdy, e_we, chk_addr;
        int e_addr;
    } vec_t;

    vec_t vt [13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge vgaclk);
        reset     = nx.rst;
        counter_H = nx.h;
        counter_V = nx.v;
        wr_valid  = nx.wv;
        wr_x      = nx.x;
        wr_y      = nx.y;
        wr_color  = nx.c;
        clr_req   = nx.cr;
        clr_color = nx.cc;
        #2;
    endtask

    function automatic bit is_act(int h, int v);
        return (h < 640) && (v < 480);
    endfunction

    function automatic bit is_disp(int h, int v);
        return is_act(h, v) && (h % 4 == 0);
    endfunction

    function automatic void adv(inout int h, inout int v);
        h++;
        if (h == 800) begin
            h = 0;
            v = (v + 1) % 525;
        end
    endfunction

    task automatic fill_row(input int r);
        for (int c = 0; c < 160; c++) begin
            @(negedge vgaclk);
            bd_we   = 1'b1;
            bd_addr = 15'(r * 160 + c);
            bd_data = 8'($urandom);
            mdl[r * 160 + c] = bd_data;
        end
        @(negedge vgaclk);
        bd_we = 1'b0;
    endtask

    task automatic run_random(input int v0, input int ncyc);
        int h, v, last, x, y, ea, r;
        bit wv, act, d, ew;
        logic [7:0] grp;
        logic [8:0] e;
        logic [8:0] hq [$];
        h = 0; v = v0; last = -1; grp = 8'h00;
        for (int n = 0; n < ncyc; n++) begin
            wv = ($urandom_range(0, 3) != 0);
            x  = ($urandom_range(0, 9) == 0) ? $urandom_range(160, 255)
                                             : $urandom_range(0, 159);
            r  = $urandom_range(0, 4);
            if (r < 2) y = (v < 480) ? v / 4 : 0;
            else if (r == 2) y = 119;
            else if (r == 3) y = 0;
            else y = $urandom_range(0, 127);
            nx    = '0;
            nx.h  = 10'(h);
            nx.v  = 10'(v);
            nx.wv = wv;
            nx.x  = 8'(x);
            nx.y  = 7'(y);
            nx.c  = 8'($urandom);
            tick();
            act = is_act(h, v);
            d   = is_disp(h, v);
            check("rnd_ready", wr_ready, !d);
            if (d) begin
                ea = (v / 4) * 160 + h / 4;
                check("rnd_disp_addr", ram_addr, ea);
                check("rnd_disp_we", ram_we, 0);
                grp  = mdl[ea];
                last = ea;
            end else if (wv) begin
                ew = (x < 160) && (y < 120);
                check("rnd_wr_we", ram_we, ew);
                if (ew) begin
                    check("rnd_wr_addr", ram_addr, y * 160 + x);
                    check("rnd_wr_data", ram_wdata, nx.c);
                    mdl[y * 160 + x] = nx.c;
                end
            end else begin
                check("rnd_idle_we", ram_we, 0);
                if (last >= 0) check("rnd_idle_addr", ram_addr, last);
            end
            hq.push_back({act, grp});
            if (hq.size() == 3) begin
                e = hq.pop_front();
                check("rnd_pixel", pixel_color, e[8] ? e[7:0] : 8'h00);
            end
            adv(h, v);
        end
    endtask

    initial begin
        int h, v, writes, cyc, e_busy, e_rdy, e_slot, e_ord, e_miss;
        bit d;

        nx = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        reset = 1'b1; counter_H = '0; counter_V = '0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
        clr_req = 1'b0; clr_color = '0;

        // reset held for three cycles during active video
        for (int i = 0; i < 5; i++) begin
            nx     = '0;
            nx.rst = (i < 3);
            nx.h   = 10'(i);
            tick();
            check($sformatf("rst_we_h%0d", i), ram_we, 0);
            check($sformatf("rst_ready_h%0d", i), wr_ready, (i % 4) != 0);
            if (i > 0) begin
                check($sformatf("rst_pixel_h%0d", i), pixel_color, 0);
                check($sformatf("rst_busy_h%0d", i), clr_busy, 0);
            end
        end

        vt[0]  = '{8,    4,    0, 0,   0,   0,    0, 0, 1, 162};
        vt[1]  = '{4,    0,    1, 3,   2,   'h5A, 0, 0, 1, 1};
        vt[2]  = '{5,    0,    1, 3,   2,   'h5A, 1, 1, 1, 323};
        vt[3]  = '{700,  10,   1, 160, 5,   'h99, 1, 0, 0, 0};
        vt[4]  = '{700,  10,   1, 159, 119, 'h33, 1, 1, 1, 19199};
        vt[5]  = '{639,  479,  1, 0,   0,   'h11, 1, 1, 1, 0};
        vt[6]  = '{636,  479,  0, 0,   0,   0,    0, 0, 1, 19199};
        vt[7]  = '{640,  0,    1, 10,  0,   'h42, 1, 1, 1, 10};
        vt[8]  = '{0,    480,  0, 0,   0,   0,    1, 0, 1, 19199};
        vt[9]  = '{0,    0,    1, 0,   120, 'h07, 0, 0, 1, 0};
        vt[10] = '{1,    0,    1, 0,   120, 'h07, 1, 0, 0, 0};
        vt[11] = '{1023, 1023, 1, 1,   1,   'hFF, 1, 1, 1, 161};
        vt[12] = '{2,    0,    0, 0,   0,   0,    1, 0, 1, 0};

        foreach (vt[i]) begin
            nx    = '0;
            nx.h  = 10'(vt[i].h);
            nx.v  = 10'(vt[i].v);
            nx.wv = vt[i].wv;
            nx.x  = 8'(vt[i].x);
            nx.y  = 7'(vt[i].y);
            nx.c  = 8'(vt[i].c);
            tick();
            check($sformatf("vec%0d_ready", i), wr_ready, vt[i].e_rdy);
            check($sformatf("vec%0d_we", i), ram_we, vt[i].e_we);
            if (vt[i].chk_addr) check($sformatf("vec%0d_addr", i), ram_addr, vt[i].e_addr);
            if (vt[i].e_we) check($sformatf("vec%0d_wdata", i), ram_wdata, vt[i].c);
        end

        // fetch: store 0xA5 at (2,1) during blanking, then scan it out
        nx = '0; nx.h = 10'd0; nx.v = 10'd500;
        nx.wv = 1'b1; nx.x = 8'd2; nx.y = 7'd1; nx.c = 8'hA5;
        tick();
        check("fetch_pre_we", ram_we, 1);
        check("fetch_pre_addr", ram_addr, 162);
        check("fetch_pre_data", ram_wdata, 8'hA5);
        for (int hh = 6; hh < 14; hh++) begin
            nx = '0; nx.h = 10'(hh); nx.v = 10'd4;
            tick();
            if (hh == 8) begin
                check("fetch_addr", ram_addr, 162);
                check("fetch_we", ram_we, 0);
            end
            if (hh >= 10) check($sformatf("fetch_pixel_h%0d", hh), pixel_color, 8'hA5);
        end

`ifdef FB_CLEAR_EN
        // full clear started together with a writer request
        h = 0; v = 490;
        nx = '0; nx.h = 10'(h); nx.v = 10'(v);
        nx.cr = 1'b1; nx.cc = 8'h1C;
        nx.wv = 1'b1; nx.x = 8'd7; nx.y = 7'd0; nx.c = 8'h77;
        tick();
        check("clr_start_busy", clr_busy, 0);
        check("clr_start_wr_we", ram_we, 1);
        check("clr_start_wr_addr", ram_addr, 7);
        check("clr_start_wr_data", ram_wdata, 8'h77);
        adv(h, v);
        writes = 0; cyc = 0;
        e_busy = 0; e_rdy = 0; e_slot = 0; e_ord = 0; e_miss = 0;
        while (writes < 19200 && cyc < 40000) begin
            nx = '0; nx.h = 10'(h); nx.v = 10'(v);
            nx.cc = 8'hE3; nx.wv = 1'b1;
            nx.x = 8'($urandom_range(0, 159));
            nx.y = 7'($urandom_range(0, 119));
            nx.c = 8'($urandom);
            tick();
            d = is_disp(h, v);
            if (cyc == 0) check("clr_busy_rise", clr_busy, 1);
            if (clr_busy !== 1'b1) e_busy++;
            if (wr_ready !== 1'b0) e_rdy++;
            if (ram_we === 1'b1) begin
                if (d) e_slot++;
                if (ram_addr !== 15'(writes) || ram_wdata !== 8'h1C) e_ord++;
                writes++;
            end else if (!d) begin
                e_miss++;
            end
            adv(h, v);
            cyc++;
        end
        check("clr_write_count", writes, 19200);
        check("clr_busy_errs", e_busy, 0);
        check("clr_ready_errs", e_rdy, 0);
        check("clr_disp_slot_errs", e_slot, 0);
        check("clr_order_errs", e_ord, 0);
        check("clr_missed_slots", e_miss, 0);
        nx = '0; nx.h = 10'(h); nx.v = 10'(v);
        tick();
        check("clr_busy_fall", clr_busy, 0);
        check("clr_done_we", ram_we, 0);
        check("clr_done_ready", wr_ready, !is_disp(h, v));
        adv(h, v);

        // reset once 5000 clear writes have been issued
        nx = '0; nx.h = 10'(h); nx.v = 10'(v); nx.cr = 1'b1; nx.cc = 8'h3C;
        tick();
        adv(h, v);
        writes = 0; cyc = 0;
        while (writes < 5000 && cyc < 10000) begin
            nx = '0; nx.h = 10'(h); nx.v = 10'(v);
            tick();
            if (ram_we === 1'b1) writes++;
            adv(h, v);
            cyc++;
        end
        check("mid_write_count", writes, 5000);
        nx = '0; nx.rst = 1'b1; nx.h = 10'(h); nx.v = 10'(v);
        tick();
        adv(h, v);
        e_busy = 0; e_rdy = 0; e_slot = 0;
        for (int i = 0; i < 40; i++) begin
            nx = '0; nx.h = 10'(h); nx.v = 10'(v);
            tick();
            if (i == 0) begin
                check("mid_busy_after_rst", clr_busy, 0);
                check("mid_ready_after_rst", wr_ready, !is_disp(h, v));
            end
            if (clr_busy !== 1'b0) e_busy++;
            if (wr_ready !== !is_disp(h, v)) e_rdy++;
            if (ram_we !== 1'b0) e_slot++;
            adv(h, v);
        end
        check("mid_busy_errs", e_busy, 0);
        check("mid_ready_errs", e_rdy, 0);
        check("mid_stray_writes", e_slot, 0);
`else
        // clear disabled: requests are ignored and the writer keeps every free slot
        h = 0; v = 0;
        for (int i = 0; i < 8; i++) begin
            nx = '0; nx.h = 10'(h); nx.v = 10'(v);
            nx.cr = 1'b1; nx.cc = 8'h1C;
            nx.wv = 1'b1; nx.x = 8'(i); nx.y = 7'd3; nx.c = 8'(i + 1);
            tick();
            check($sformatf("noclr_busy_%0d", i), clr_busy, 0);
            check($sformatf("noclr_ready_%0d", i), wr_ready, !is_disp(h, v));
            check($sformatf("noclr_we_%0d", i), ram_we, !is_disp(h, v));
            adv(h, v);
        end
`endif

        nx = '0;
        tick();
        fill_row(0);
        fill_row(119);
        run_random(476, 2400);
        run_random(0, 2400);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
